// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: latches edge/level requests, masks them, raises one registered
// request to the core and tracks a single in-flight trap through the ack/done handshake.
module irq_controller #(
    parameter int unsigned        NUM_IRQ   = 4,
    parameter int unsigned        ID_W      = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MODE = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               intrrupt,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               irq_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_IRQ-1:0] src_prev_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic               intr_q;
    logic [ID_W-1:0]    id_q;
    logic               busy_q;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [ID_W-1:0]    winner;
    logic               any_elig;
    logic               cur_elig;

    always_comb begin
        rise     = irq_src & ~src_prev_q;
        eligible = pending_q & irq_enable;
        any_elig = |eligible;

        // Scan downward so the lowest eligible index is the one left standing.
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end

        cur_elig = 1'b0;
        ack_clr  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (id_q == ID_W'(i)) begin
                cur_elig   = eligible[i];
                ack_clr[i] = (state_q == ASSERT) && irq_ack && EDGE_MODE[i];
            end
        end

        // A fresh edge on the channel being acked keeps it pending.
        pending_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MODE[i]) begin
                pending_d[i] = (pending_q[i] & ~ack_clr[i]) | rise[i];
            end else begin
                pending_d[i] = irq_src[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            src_prev_q <= irq_src;
            pending_q  <= '0;
            intr_q     <= 1'b0;
            id_q       <= '0;
            busy_q     <= 1'b0;
        end else begin
            src_prev_q <= irq_src;
            pending_q  <= pending_d;
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        id_q    <= winner;
                        intr_q  <= 1'b1;
                        state_q <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (irq_ack) begin
                        intr_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SERVICE;
                    end else if (!cur_elig) begin
                        intr_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SERVICE: begin
                    if (irq_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    intr_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign intrrupt    = intr_q;
    assign irq_id      = id_q;
    assign irq_pending = pending_q;
    assign irq_busy    = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed stimulus pushes expected output snapshots; a monitor pops and
// compares one snapshot each time the DUT's observable outputs change.
module tb_irq_controller;

    logic       clk;
    logic       reset;
    logic [3:0] irq_src;
    logic [3:0] irq_enable;
    logic       irq_ack;
    logic       irq_done;
    logic       intrrupt;
    logic [1:0] irq_id;
    logic [3:0] irq_pending;
    logic       irq_busy;

    typedef struct packed {
        logic       intr;
        logic [1:0] id;
        logic [3:0] pend;
        logic       busy;
    } snap_t;

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    logic  mon_en = 1'b0;

    irq_controller #(
        .NUM_IRQ  (4),
        .ID_W     (2),
        .EDGE_MODE(4'b1110)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .irq_enable (irq_enable),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .intrrupt   (intrrupt),
        .irq_id     (irq_id),
        .irq_pending(irq_pending),
        .irq_busy   (irq_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Monitor: every change of the output bundle consumes one expected snapshot.
    initial begin
        snap_t cur;
        snap_t prev;
        snap_t e;
        bit    first;
        first = 1'b1;
        prev  = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            cur.intr = intrrupt;
            cur.id   = irq_id;
            cur.pend = irq_pending;
            cur.busy = irq_busy;
            if (first || (cur !== prev)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change #%0d: got intr=%0b id=%0d pend=%b busy=%0b, required no change",
                             total, cur.intr, cur.id, cur.pend, cur.busy);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL snapshot #%0d: got intr=%0b id=%0d pend=%b busy=%0b, required intr=%0b id=%0d pend=%b busy=%0b",
                                 total, cur.intr, cur.id, cur.pend, cur.busy, e.intr, e.id, e.pend, e.busy);
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input logic i, input logic [1:0] id, input logic [3:0] p, input logic b);
        snap_t s;
        s.intr = i;
        s.id   = id;
        s.pend = p;
        s.busy = b;
        exp_q.push_back(s);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1;
        tick(1);
        irq_done = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        irq_src    = 4'b0000;
        irq_enable = 4'b1111;
        irq_ack    = 1'b0;
        irq_done   = 1'b0;

        // Reset state
        expect_out(1'b0, 2'd0, 4'b0000, 1'b0);
        tick(2);
        mon_en = 1'b1;
        reset  = 1'b0;
        tick(2);

        // 1: single edge pulse on ch2, ack, ignored second ack, done
        irq_src = 4'b0100;
        expect_out(1'b0, 2'd0, 4'b0100, 1'b0);
        tick(1);
        irq_src = 4'b0000;
        expect_out(1'b1, 2'd2, 4'b0100, 1'b0);
        tick(3);
        expect_out(1'b0, 2'd2, 4'b0000, 1'b1);
        pulse_ack();
        tick(1);
        pulse_ack();
        expect_out(1'b0, 2'd2, 4'b0000, 1'b0);
        pulse_done();
        tick(3);

        // 2: ch1 and ch3 together; ch1 first, ch3 one edge after done
        irq_src = 4'b1010;
        expect_out(1'b0, 2'd2, 4'b1010, 1'b0);
        tick(1);
        irq_src = 4'b0000;
        expect_out(1'b1, 2'd1, 4'b1010, 1'b0);
        tick(2);
        expect_out(1'b0, 2'd1, 4'b1000, 1'b1);
        pulse_ack();
        expect_out(1'b0, 2'd1, 4'b1000, 1'b0);
        expect_out(1'b1, 2'd3, 4'b1000, 1'b0);
        pulse_done();
        tick(1);
        expect_out(1'b0, 2'd3, 4'b0000, 1'b1);
        pulse_ack();
        expect_out(1'b0, 2'd3, 4'b0000, 1'b0);
        pulse_done();
        tick(2);

        // 3: higher-priority ch1 arrives while ch3 is asserted; no preemption
        irq_src = 4'b1000;
        expect_out(1'b0, 2'd3, 4'b1000, 1'b0);
        tick(1);
        irq_src = 4'b0000;
        expect_out(1'b1, 2'd3, 4'b1000, 1'b0);
        tick(1);
        irq_src = 4'b0010;
        expect_out(1'b1, 2'd3, 4'b1010, 1'b0);
        tick(1);
        irq_src = 4'b0000;
        tick(2);
        expect_out(1'b0, 2'd3, 4'b0010, 1'b1);
        pulse_ack();
        expect_out(1'b0, 2'd3, 4'b0010, 1'b0);
        expect_out(1'b1, 2'd1, 4'b0010, 1'b0);
        pulse_done();
        tick(1);
        expect_out(1'b0, 2'd1, 4'b0000, 1'b1);
        pulse_ack();
        expect_out(1'b0, 2'd1, 4'b0000, 1'b0);
        pulse_done();
        tick(2);

        // New edge on the same channel as the ack: pending survives and re-fires after done
        irq_src = 4'b0100;
        expect_out(1'b0, 2'd1, 4'b0100, 1'b0);
        tick(1);
        irq_src = 4'b0000;
        expect_out(1'b1, 2'd2, 4'b0100, 1'b0);
        tick(1);
        irq_src = 4'b0100;
        irq_ack = 1'b1;
        expect_out(1'b0, 2'd2, 4'b0100, 1'b1);
        tick(1);
        irq_src = 4'b0000;
        irq_ack = 1'b0;
        expect_out(1'b0, 2'd2, 4'b0100, 1'b0);
        expect_out(1'b1, 2'd2, 4'b0100, 1'b0);
        pulse_done();
        tick(1);
        expect_out(1'b0, 2'd2, 4'b0000, 1'b1);
        pulse_ack();
        expect_out(1'b0, 2'd2, 4'b0000, 1'b0);
        pulse_done();
        tick(2);

        // 4: level ch0 held through done re-fires; dropping it in ASSERT withdraws
        irq_src = 4'b0001;
        expect_out(1'b0, 2'd2, 4'b0001, 1'b0);
        tick(1);
        expect_out(1'b1, 2'd0, 4'b0001, 1'b0);
        tick(1);
        expect_out(1'b0, 2'd0, 4'b0001, 1'b1);
        pulse_ack();
        expect_out(1'b0, 2'd0, 4'b0001, 1'b0);
        expect_out(1'b1, 2'd0, 4'b0001, 1'b0);
        pulse_done();
        tick(1);
        irq_src = 4'b0000;
        expect_out(1'b1, 2'd0, 4'b0000, 1'b0);
        expect_out(1'b0, 2'd0, 4'b0000, 1'b0);
        tick(3);

        // 5: masked pending waits; enabling asserts next edge; masking in ASSERT withdraws
        irq_enable = 4'b1101;
        irq_src    = 4'b0010;
        expect_out(1'b0, 2'd0, 4'b0010, 1'b0);
        tick(1);
        irq_src = 4'b0000;
        tick(3);
        irq_enable = 4'b1111;
        expect_out(1'b1, 2'd1, 4'b0010, 1'b0);
        tick(1);
        irq_enable = 4'b1101;
        expect_out(1'b0, 2'd1, 4'b0010, 1'b0);
        tick(1);
        irq_enable = 4'b1111;
        expect_out(1'b1, 2'd1, 4'b0010, 1'b0);
        tick(1);
        expect_out(1'b0, 2'd1, 4'b0000, 1'b1);
        pulse_ack();
        expect_out(1'b0, 2'd1, 4'b0000, 1'b0);
        pulse_done();
        pulse_ack();
        tick(2);

        // 6: reset during SERVICE with source held high; no edge after release
        irq_src = 4'b0100;
        expect_out(1'b0, 2'd1, 4'b0100, 1'b0);
        tick(1);
        expect_out(1'b1, 2'd2, 4'b0100, 1'b0);
        tick(1);
        expect_out(1'b0, 2'd2, 4'b0000, 1'b1);
        pulse_ack();
        tick(1);
        reset = 1'b1;
        expect_out(1'b0, 2'd0, 4'b0000, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(4);
        irq_src = 4'b0000;
        tick(3);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations: got %0d unconsumed, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
